// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes and FSM state encoding shared by the sequential ALU.
package alu_seq_pkg;
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_XOR = 3'b010,
        OP_SHL = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_MUL = 3'b110,
        OP_CLR = 3'b111
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_e;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               run;
    // product is left untouched once done so the parent can read it afterwards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run     <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= {{WIDTH{1'b0}}, a};
                mplier  <= b;
                product <= '0;
                cnt     <= CW'(WIDTH);
                run     <= 1'b1;
            end else if (run) begin
                if (mplier[0]) product <= product + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/alu_seq_acc.sv
// alu_seq_acc: clocked ALU with accumulator; operands latched on start, result and flags held until the next op.
module alu_seq_acc
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               use_acc,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   acc,
    output logic               carry,
    output logic               zero,
    output logic               neg
);
    state_e             state, state_n;
    op_e                op_q;
    logic [WIDTH-1:0]   opa, opb, op_a_in;
    logic               fin, accept, mul_done;
    logic [2*WIDTH-1:0] product, shl, res;
    logic [WIDTH:0]     sum;
    logic               cy, ng;

    // fin is the commit cycle between computing and presenting done; busy covers it
    // so a use_acc op can never be accepted before acc has been updated
    assign busy    = (state != S_IDLE) || fin;
    assign accept  = start && !busy;
    assign op_a_in = use_acc ? acc : a;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && op_e'(op) == OP_MUL),
        .a       (op_a_in),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state == S_IDLE ? (accept ? (op_e'(op) == OP_MUL ? S_MUL : S_EXEC) : S_IDLE)
                : state == S_MUL  ? (mul_done ? S_IDLE : S_MUL)
                : S_IDLE;
    end

    always_comb begin
        sum = {1'b0, opa} + {1'b0, opb};
        shl = {{WIDTH{1'b0}}, opa} << opb[SHIFT_W-1:0];
        res = '0;
        cy  = 1'b0;
        ng  = 1'b0;
        case (op_q)
            OP_ADD: begin res = {{(WIDTH-1){1'b0}}, sum}; cy = sum[WIDTH]; end
            OP_SUB: begin res = {{WIDTH{1'b0}}, opa - opb}; cy = opa < opb; ng = opa < opb; end
            OP_XOR: res = {{WIDTH{1'b0}}, opa ^ opb};
            OP_AND: res = {{WIDTH{1'b0}}, opa & opb};
            OP_OR:  res = {{WIDTH{1'b0}}, opa | opb};
            OP_SHL: begin res = shl; cy = |shl[2*WIDTH-1:WIDTH]; end
            OP_MUL: begin res = product; cy = |product[2*WIDTH-1:WIDTH]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fin    <= 1'b0;
            done   <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            op_q   <= OP_ADD;
            result <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else begin
            fin  <= (state == S_EXEC) || (state == S_MUL && mul_done);
            done <= fin;
            if (accept) begin
                opa  <= op_a_in;
                opb  <= b;
                op_q <= op_e'(op);
            end
            if (fin) begin
                result <= res;
                acc    <= res[WIDTH-1:0];
                carry  <= cy;
                zero   <= res == '0;
                neg    <= ng;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_acc.sv
// tb_alu_seq_acc: scoreboard bench; a behavioural model predicts each op, a monitor checks every done pulse.
module tb_alu_seq_acc;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         use_acc = 1'b0;
    logic         busy, done, carry, zero, neg;
    logic [2*W-1:0] result;
    logic [W-1:0] acc;

    typedef struct {
        int res;
        int acc;
        int c;
        int z;
        int n;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   model_acc = 0;
    logic prev_done = 1'b0;

    alu_seq_acc #(.WIDTH(W), .SHIFT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .use_acc (use_acc),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .acc     (acc),
        .carry   (carry),
        .zero    (zero),
        .neg     (neg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                e = sbq.pop_front();
                chk("result", 32'(result), e.res);
                chk("acc", 32'(acc), e.acc);
                chk("carry", 32'(carry), e.c);
                chk("zero", 32'(zero), e.z);
                chk("neg", 32'(neg), e.n);
                chk("latency", cyc, e.cyc);
                chk("busy_low_at_done", 32'(busy), 32'd0);
            end
        end
        if (rst_n && prev_done) chk("done_one_cycle", 32'(done), 32'd0);
        prev_done <= done;
    end

    // Reference model: values come straight from the arithmetic definitions of each opcode.
    task automatic issue(input int o, input int av, input int bv, input bit ua, input bit push);
        int n, x, r, c, ng;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            chk("issue_timeout", 32'd1, 32'd0);
            return;
        end
        start = 1'b1;
        op = 3'(o);
        a = W'(av);
        b = W'(bv);
        use_acc = ua;
        if (push) begin
            x = ua ? model_acc : av;
            c = 0;
            ng = 0;
            case (o)
                0: begin r = x + bv; c = int'(r > 255); end
                1: begin r = (x - bv) & 255; c = int'(x < bv); ng = c; end
                2: r = x ^ bv;
                3: begin r = (x << (bv % 8)) & 65535; c = int'(r > 255); end
                4: r = x & bv;
                5: r = x | bv;
                6: begin r = x * bv; c = int'(r > 255); end
                default: r = 0;
            endcase
            sbq.push_back('{r, r & 255, c, int'(r == 0), ng, cyc + 1 + (o == 6 ? W + 2 : 2)});
            model_acc = r & 255;
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_neg", 32'(neg), 32'd0);
        rst_n = 1'b1;

        issue(0, 5, 6, 0, 1);
        issue(0, 200, 100, 0, 1);
        issue(1, 2, 5, 0, 1);
        issue(1, 5, 2, 0, 1);
        issue(6, 255, 255, 0, 1);
        repeat (3) @(negedge clk);
        chk("busy_mid_mul", 32'(busy), 32'd1);
        start = 1'b1;
        op = 3'b000;
        a = 8'd1;
        b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        drain();

        issue(7, 0, 0, 0, 1);
        repeat (4) issue(0, 0, 70, 1, 1);
        issue(3, 8'h81, 1, 0, 1);
        issue(3, 8'hff, 7, 0, 1);
        issue(2, 8'haa, 8'haa, 0, 1);
        issue(6, 0, 200, 0, 1);
        issue(6, 12, 10, 1, 1);
        drain();

        issue(6, 255, 255, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_acc = 0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_acc", 32'(acc), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        repeat (14) @(negedge clk);
        issue(0, 0, 9, 1, 1);
        drain();

        repeat (150) begin
            issue($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 3) == 0, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
